// File: rtl/morse_pkg.sv
// Shared types for the Morse key path: symbol codes consumed by the character
// lookup stage, classifier state encoding and the default time-unit length.
package morse_pkg;

    typedef enum logic [1:0] {
        DOT        = 2'd0,
        DASH       = 2'd1,
        LETTER_END = 2'd2,
        WORD_END   = 2'd3
    } sym_code_t;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        MARK       = 2'd1,
        SPACE      = 2'd2,
        LETTER_GAP = 2'd3
    } state_t;

    // 100 ms per Morse unit at 100 MHz
    localparam int DEFAULT_UNIT_TICKS = 10_000_000;

endpackage

// File: rtl/morse_unit_ticker.sv
// Time-unit measurement: prescaler of UNIT_TICKS cycles feeding a saturating
// unit counter. The clear cycle itself counts as tick 0 of the new interval.
module morse_unit_ticker
    import morse_pkg::*;
#(
    parameter int UNIT_TICKS = DEFAULT_UNIT_TICKS,
    parameter int MAX_UNITS  = 15,
    parameter int UNITS_W    = $clog2(MAX_UNITS + 1)
) (
    input  logic               clk_100Mhz,
    input  logic               reset_n,
    input  logic               clear,
    input  logic               enable,
    output logic [UNITS_W-1:0] units
);

    localparam int                  PRESC_W    = (UNIT_TICKS > 1) ? $clog2(UNIT_TICKS) : 1;
    localparam logic [PRESC_W-1:0]  PRESC_LAST = PRESC_W'(UNIT_TICKS - 1);
    localparam logic [UNITS_W-1:0]  UNITS_MAX  = UNITS_W'(MAX_UNITS);

    logic [PRESC_W-1:0] presc;
    logic [PRESC_W-1:0] presc_eff;
    logic [UNITS_W-1:0] units_eff;
    logic               presc_wrap;

    always_comb begin
        presc_eff  = clear ? '0 : presc;
        units_eff  = clear ? '0 : units;
        presc_wrap = (presc_eff == PRESC_LAST);
    end

    always_ff @(posedge clk_100Mhz or negedge reset_n) begin
        if (!reset_n) begin
            presc <= '0;
            units <= '0;
        end else if (clear || enable) begin
            presc <= presc_wrap ? '0 : presc_eff + 1'b1;
            if (presc_wrap && (units_eff != UNITS_MAX))
                units <= units_eff + 1'b1;
            else
                units <= units_eff;
        end
    end

endmodule

// File: rtl/morse_element_classifier.sv
// Classifies debounced key mark/space durations into DOT, DASH, LETTER_END and
// WORD_END, delivered through a single-entry valid/ready output register.
//
//   state      | meaning
//   IDLE       | key released, no gap pending
//   MARK       | key pressed, measuring mark length
//   SPACE      | released after a mark, waiting for letter gap
//   LETTER_GAP | letter ended, waiting for word gap
module morse_element_classifier
    import morse_pkg::*;
#(
    parameter int UNIT_TICKS       = DEFAULT_UNIT_TICKS,
    parameter int DASH_MIN_UNITS   = 2,
    parameter int LETTER_GAP_UNITS = 2,
    parameter int WORD_GAP_UNITS   = 5,
    parameter int MAX_UNITS        = 15
) (
    input  logic       clk_100Mhz,
    input  logic       reset_n,
    input  logic       key_in,
    output logic       sym_valid,
    input  logic       sym_ready,
    output logic [1:0] sym_code,
    output logic       sym_drop
);

    localparam int UNITS_W = $clog2(MAX_UNITS + 1);

    state_t             state;
    sym_code_t          code_q;
    sym_code_t          emit_code;
    logic               emit;
    logic               key_q;
    logic               key_edge;
    logic [UNITS_W-1:0] units;

    assign key_edge = (key_in != key_q);
    assign sym_code = code_q;

    morse_unit_ticker #(
        .UNIT_TICKS (UNIT_TICKS),
        .MAX_UNITS  (MAX_UNITS),
        .UNITS_W    (UNITS_W)
    ) u_ticker (
        .clk_100Mhz (clk_100Mhz),
        .reset_n    (reset_n),
        .clear      (key_edge),
        .enable     (state != IDLE),
        .units      (units)
    );

    // An edge always beats a gap threshold reached in the same cycle.
    always_comb begin
        emit      = 1'b0;
        emit_code = DOT;
        unique case (state)
            MARK: begin
                if (key_edge) begin
                    emit      = 1'b1;
                    emit_code = (units >= UNITS_W'(DASH_MIN_UNITS)) ? DASH : DOT;
                end
            end
            SPACE: begin
                if (!key_edge && (units >= UNITS_W'(LETTER_GAP_UNITS))) begin
                    emit      = 1'b1;
                    emit_code = LETTER_END;
                end
            end
            LETTER_GAP: begin
                if (!key_edge && (units >= UNITS_W'(WORD_GAP_UNITS))) begin
                    emit      = 1'b1;
                    emit_code = WORD_END;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_100Mhz or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            key_q     <= 1'b0;
            sym_valid <= 1'b0;
            code_q    <= DOT;
            sym_drop  <= 1'b0;
        end else begin
            key_q <= key_in;

            unique case (state)
                IDLE:       if (key_edge) state <= MARK;
                MARK:       if (key_edge) state <= SPACE;
                SPACE: begin
                    if (key_edge)  state <= MARK;
                    else if (emit) state <= LETTER_GAP;
                end
                LETTER_GAP: begin
                    if (key_edge)  state <= MARK;
                    else if (emit) state <= IDLE;
                end
                default:    state <= IDLE;
            endcase

            // A held symbol blocks new ones until the consumer takes it.
            sym_drop <= 1'b0;
            if (emit) begin
                if (!sym_valid || sym_ready) begin
                    sym_valid <= 1'b1;
                    code_q    <= emit_code;
                end else begin
                    sym_drop <= 1'b1;
                end
            end else if (sym_valid && sym_ready) begin
                sym_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_morse_element_classifier.sv
// Bench for morse_element_classifier: directed and random key sequences checked
// each cycle against a run-length model of the classifier and output register.
module tb_morse_element_classifier;

    localparam int UT     = 4;
    localparam int DASH_U = 2;
    localparam int LG_U   = 2;
    localparam int WG_U   = 5;
    localparam int MAX_U  = 15;

    logic       clk_100Mhz = 1'b0;
    logic       reset_n;
    logic       key_in;
    logic       sym_valid;
    logic       sym_ready;
    logic [1:0] sym_code;
    logic       sym_drop;

    int n_cmp = 0;
    int n_err = 0;

    logic       m_prev;
    logic       m_armed;
    int         hi_len;
    int         lo_len;
    logic       m_valid;
    logic [1:0] m_code;
    logic       m_drop;

    always #5 clk_100Mhz = ~clk_100Mhz;

    morse_element_classifier #(
        .UNIT_TICKS       (UT),
        .DASH_MIN_UNITS   (DASH_U),
        .LETTER_GAP_UNITS (LG_U),
        .WORD_GAP_UNITS   (WG_U),
        .MAX_UNITS        (MAX_U)
    ) dut (
        .clk_100Mhz (clk_100Mhz),
        .reset_n    (reset_n),
        .key_in     (key_in),
        .sym_valid  (sym_valid),
        .sym_ready  (sym_ready),
        .sym_code   (sym_code),
        .sym_drop   (sym_drop)
    );

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s at %0t: observed=%0d expected=%0d", tag, $time, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_prev  = 1'b0;
        m_armed = 1'b0;
        hi_len  = 0;
        lo_len  = 0;
        m_valid = 1'b0;
        m_code  = 2'd0;
        m_drop  = 1'b0;
    endtask

    // Mark = number of high cycles; gaps fire when the low run (counting the
    // release cycle) spans gap_units*UT+1 cycles, i.e. the threshold cycle itself.
    task automatic model_update(input logic k, input logic r);
        logic       e;
        logic [1:0] ec;
        int         u;
        e  = 1'b0;
        ec = 2'd0;
        if (k != m_prev) begin
            if (k) begin
                m_armed = 1'b1;
                hi_len  = 1;
            end else begin
                u = hi_len / UT;
                if (u > MAX_U) u = MAX_U;
                e      = 1'b1;
                ec     = (u >= DASH_U) ? 2'd1 : 2'd0;
                lo_len = 1;
            end
        end else if (k) begin
            hi_len++;
        end else begin
            lo_len++;
            if (m_armed && lo_len == LG_U * UT + 1) begin
                e  = 1'b1;
                ec = 2'd2;
            end else if (m_armed && lo_len == WG_U * UT + 1) begin
                e       = 1'b1;
                ec      = 2'd3;
                m_armed = 1'b0;
            end
        end
        m_prev = k;

        m_drop = 1'b0;
        if (e) begin
            if (!m_valid || r) begin
                m_valid = 1'b1;
                m_code  = ec;
            end else begin
                m_drop = 1'b1;
            end
        end else if (m_valid && r) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic compare_all();
        chk("sym_valid", {1'b0, sym_valid}, {1'b0, m_valid});
        chk("sym_code",  sym_code,          m_code);
        chk("sym_drop",  {1'b0, sym_drop},  {1'b0, m_drop});
    endtask

    task automatic step(input logic k, input logic r);
        @(negedge clk_100Mhz);
        key_in    = k;
        sym_ready = r;
        @(posedge clk_100Mhz);
        model_update(k, r);
        #1;
        compare_all();
    endtask

    task automatic run(input logic k, input int n, input logic r);
        for (int i = 0; i < n; i++) step(k, r);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic cur;
        reset_n   = 1'b0;
        key_in    = 1'b0;
        sym_ready = 1'b0;
        model_reset();
        #1;
        chk("rst_valid", {1'b0, sym_valid}, 2'd0);
        chk("rst_code",  sym_code,          2'd0);
        chk("rst_drop",  {1'b0, sym_drop},  2'd0);
        @(negedge clk_100Mhz);
        reset_n = 1'b1;

        // idle with key up: nothing emitted
        run(1'b0, 30, 1'b1);

        // 7-cycle press -> DOT, then letter and word gaps
        run(1'b1, 7, 1'b1);
        run(1'b0, 25, 1'b1);

        // 8-cycle press -> DASH; 200-cycle press saturates -> DASH
        run(1'b1, 8, 1'b1);
        run(1'b0, 3, 1'b1);
        run(1'b1, 200, 1'b1);
        run(1'b0, 25, 1'b1);

        // 7-cycle gap: no LETTER_END; rise on threshold cycle suppresses it
        run(1'b1, 3, 1'b1);
        run(1'b0, 7, 1'b1);
        run(1'b1, 3, 1'b1);
        run(1'b0, 8, 1'b1);
        run(1'b1, 2, 1'b1);
        run(1'b0, 25, 1'b1);

        // backpressure: DOT held, LETTER_END dropped, DOT delivered later
        run(1'b1, 3, 1'b0);
        run(1'b0, 12, 1'b0);
        run(1'b0, 2, 1'b1);
        run(1'b0, 15, 1'b1);

        // transfer coincides with LETTER_END emission
        run(1'b1, 3, 1'b0);
        run(1'b0, 8, 1'b0);
        step(1'b0, 1'b1);
        chk("coincide_code", sym_code, 2'd2);
        run(1'b0, 15, 1'b1);

        // async reset mid-MARK with a held symbol
        run(1'b1, 3, 1'b0);
        run(1'b0, 2, 1'b0);
        run(1'b1, 5, 1'b0);
        chk("pre_rst_valid", {1'b0, sym_valid}, 2'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_valid", {1'b0, sym_valid}, 2'd0);
        chk("arst_code",  sym_code,          2'd0);
        chk("arst_drop",  {1'b0, sym_drop},  2'd0);
        model_reset();
        key_in = 1'b1;
        repeat (2) @(negedge clk_100Mhz);
        reset_n   = 1'b1;
        key_in    = 1'b1;
        sym_ready = 1'b1;
        @(posedge clk_100Mhz);
        model_update(1'b1, 1'b1);
        #1;
        compare_all();
        run(1'b1, 8, 1'b1);
        run(1'b0, 1, 1'b1);
        chk("post_rst_dash", sym_code, 2'd1);
        run(1'b0, 24, 1'b1);

        // random mark/space runs with random backpressure
        cur = 1'b0;
        for (int it = 0; it < 60; it++) begin
            int len;
            cur = ~cur;
            len = int'($urandom_range(1, 26));
            for (int c = 0; c < len; c++)
                step(cur, ($urandom_range(0, 3) != 0));
        end
        run(1'b0, 25, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
